// File: rtl/line_buffer_scheduler.sv
// Purpose: sequences accepted pixels into the line-buffer cascade and tracks window/line/frame position.
// Latency: lb_enable is combinational from pixel_valid; all status outputs follow one cycle after the accepting edge.
// Backpressure: none upstream; pixels outside a frame, or offered in the DONE cycle, are dropped (lb_enable low).
module line_buffer_scheduler #(
  parameter int IMG_WIDTH  = 317,
  parameter int IMG_HEIGHT = 240,
  parameter int KERNEL     = 3,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pixel_valid,
  input  logic             frame_start,
  output logic             lb_enable,
  output logic             window_valid,
  output logic [COL_W-1:0] col_count,
  output logic [ROW_W-1:0] row_count,
  output logic             line_end,
  output logic             frame_done,
  output logic             busy,
  output logic             sync_err
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] WIN_COL  = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] WIN_ROW  = ROW_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] FILL_END = ROW_W'(KERNEL - 2);

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] nx, nx_nxt, acc_c;
  logic [ROW_W-1:0] ny, ny_nxt, acc_r;
  logic             in_frame;
  logic             restart;
  logic             last_col;
  logic             last_pix;

  // State register; reset drops straight back to IDLE without waiting for an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accept decision, position of the accepted pixel, next position and next state.
  always_comb begin
    state_nxt = state;
    in_frame  = (state == FILL) || (state == ACTIVE);
    lb_enable = reset_n & pixel_valid & (((state == IDLE) & frame_start) | in_frame);
    restart   = lb_enable & frame_start & in_frame;
    // A frame_start pixel always lands at (0,0), whether it opens a frame or restarts one.
    acc_c     = frame_start ? '0 : nx;
    acc_r     = frame_start ? '0 : ny;
    last_col  = (acc_c == LAST_COL);
    last_pix  = last_col & (acc_r == LAST_ROW);
    nx_nxt    = nx;
    ny_nxt    = ny;
    if (lb_enable) begin
      if (last_col) begin
        nx_nxt = '0;
        ny_nxt = acc_r + 1'b1;
      end else begin
        nx_nxt = acc_c + 1'b1;
        ny_nxt = acc_r;
      end
      // State follows purely from where the accepted pixel sits in the frame.
      if (last_pix) begin
        state_nxt = DONE;
      end else if ((acc_r >= WIN_ROW) || ((acc_r == FILL_END) && last_col)) begin
        state_nxt = ACTIVE;
      end else begin
        state_nxt = FILL;
      end
    end else if (state == DONE) begin
      state_nxt = IDLE;
    end
  end

  // Next-position counters; they only move on accepted pixels so gaps hold them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nx <= '0;
      ny <= '0;
    end else begin
      nx <= nx_nxt;
      ny <= ny_nxt;
    end
  end

  // Status outputs, aligned with the line-buffer taps updated on the same accepting edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_count    <= '0;
      row_count    <= '0;
      window_valid <= 1'b0;
      line_end     <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      busy <= (state_nxt == FILL) || (state_nxt == ACTIVE);
      if (lb_enable) begin
        col_count    <= acc_c;
        row_count    <= acc_r;
        window_valid <= (acc_r >= WIN_ROW) && (acc_c >= WIN_COL);
        line_end     <= last_col;
        frame_done   <= last_pix;
        sync_err     <= restart;
      end else begin
        window_valid <= 1'b0;
        line_end     <= 1'b0;
        frame_done   <= 1'b0;
        sync_err     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Purpose: self-checking bench for line_buffer_scheduler on a 5x4 image with a 3x3 window.
// Latency: checks lb_enable before each edge and registered outputs 1 time unit after it.
// Backpressure: n/a; stimulus is driven one cycle at a time.
module tb_line_buffer_scheduler;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int K  = 3;
  localparam int CW = 3;
  localparam int RW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          pixel_valid;
  logic          frame_start;
  logic          lb_enable;
  logic          window_valid;
  logic [CW-1:0] col_count;
  logic [RW-1:0] row_count;
  logic          line_end;
  logic          frame_done;
  logic          busy;
  logic          sync_err;

  int checks = 0;
  int errors = 0;

  // Frame-level reference model: position is the accept index within the frame.
  bit m_inframe, m_done, m_wv, m_le, m_fd, m_se, m_busy;
  int m_k, m_r, m_c;

  int cnt_wv, cnt_le, cnt_fd;

  line_buffer_scheduler #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K), .COL_W(CW), .ROW_W(RW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .lb_enable(lb_enable), .window_valid(window_valid), .col_count(col_count),
    .row_count(row_count), .line_end(line_end), .frame_done(frame_done),
    .busy(busy), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inframe = 0; m_done = 0; m_wv = 0; m_le = 0; m_fd = 0; m_se = 0; m_busy = 0;
    m_k = 0; m_r = 0; m_c = 0;
  endtask

  // One clock of stimulus; checks lb_enable before the edge and every output after it.
  task automatic step(input bit pv, input bit fs, output bit lb_seen);
    bit acc;
    pixel_valid = pv;
    frame_start = fs;
    #1;
    acc     = pv && !m_done && (m_inframe || fs);
    lb_seen = lb_enable;
    chk("lb_enable", lb_enable, acc);
    @(posedge clock);
    #1;
    if (acc) begin
      m_se = fs && m_inframe;
      if (fs) m_k = 0;
      m_r  = m_k / W;
      m_c  = m_k % W;
      m_wv = (m_r >= K - 1) && (m_c >= K - 1);
      m_le = (m_c == W - 1);
      m_fd = (m_k == W * H - 1);
      m_done    = m_fd;
      m_inframe = !m_fd;
      m_k++;
    end else begin
      m_wv = 0; m_le = 0; m_fd = 0; m_se = 0; m_done = 0;
    end
    m_busy = m_inframe;
    chk("window_valid", window_valid, m_wv);
    chk("line_end", line_end, m_le);
    chk("frame_done", frame_done, m_fd);
    chk("sync_err", sync_err, m_se);
    chk("busy", busy, m_busy);
    chk("row_count", row_count, m_r);
    chk("col_count", col_count, m_c);
    cnt_wv += int'(window_valid);
    cnt_le += int'(line_end);
    cnt_fd += int'(frame_done);
  endtask

  // Asserts reset between edges and checks outputs clear before any clock edge.
  task automatic async_reset();
    reset_n = 1'b0;
    pixel_valid = 1'b1;
    frame_start = 1'b1;
    #1;
    chk("rst_lb_enable", lb_enable, 0);
    chk("rst_window_valid", window_valid, 0);
    chk("rst_line_end", line_end, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_row", row_count, 0);
    chk("rst_col", col_count, 0);
    model_reset();
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic clear_counts();
    cnt_wv = 0; cnt_le = 0; cnt_fd = 0;
  endtask

  typedef struct {
    bit pv; bit fs;
    bit lb; bit wv; bit le; bit fd; bit se; bit bz;
    int row; int col;
  } vec_t;

  initial begin
    vec_t vt[9];
    bit   lb;
    bit   fs;

    reset_n = 1'b1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    model_reset();
    clear_counts();
    #2;
    async_reset();

    // Idle pixels without frame_start are ignored, then the frame opens at (0,0).
    vt[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 0};
    vt[4] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 1};
    vt[5] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vt[6] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 2};
    vt[7] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 3};
    vt[8] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 4};
    for (int i = 0; i < 9; i++) begin
      step(vt[i].pv, vt[i].fs, lb);
      chk("tbl_lb", lb, vt[i].lb);
      chk("tbl_wv", window_valid, vt[i].wv);
      chk("tbl_le", line_end, vt[i].le);
      chk("tbl_fd", frame_done, vt[i].fd);
      chk("tbl_se", sync_err, vt[i].se);
      chk("tbl_busy", busy, vt[i].bz);
      chk("tbl_row", row_count, vt[i].row);
      chk("tbl_col", col_count, vt[i].col);
    end
    for (int i = 0; i < 16; i++) step(1, 0, lb);
    step(0, 0, lb);

    // Continuous frame.
    async_reset();
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      step(1, i == 0, lb);
      if (i == 19) begin
        chk("s1_fd_row", row_count, 3);
        chk("s1_fd_col", col_count, 4);
        chk("s1_fd_busy", busy, 0);
      end
    end
    chk("s1_wv_count", cnt_wv, 6);
    chk("s1_le_count", cnt_le, 4);
    chk("s1_fd_count", cnt_fd, 1);
    step(0, 0, lb);

    // Same frame with pixel_valid toggling.
    clear_counts();
    for (int i = 0; i < 40; i++) step(i % 2 == 0, i == 0, lb);
    chk("s2_wv_count", cnt_wv, 6);
    chk("s2_le_count", cnt_le, 4);
    chk("s2_fd_count", cnt_fd, 1);

    // Restart mid-frame at accept index 12.
    step(0, 0, lb);
    for (int i = 0; i < 12; i++) step(1, i == 0, lb);
    step(1, 1, lb);
    chk("s4_sync_err", sync_err, 1);
    chk("s4_row", row_count, 0);
    chk("s4_col", col_count, 0);
    chk("s4_busy", busy, 1);
    clear_counts();
    for (int i = 0; i < 11; i++) step(1, 0, lb);
    chk("s4_no_wv", cnt_wv, 0);
    step(1, 0, lb);
    chk("s4_first_wv", window_valid, 1);
    for (int i = 0; i < 7; i++) step(1, 0, lb);
    chk("s4_fd", frame_done, 1);

    // Reset mid-frame at accept index 15, then a clean frame.
    step(0, 0, lb);
    for (int i = 0; i < 15; i++) step(1, i == 0, lb);
    async_reset();
    clear_counts();
    for (int i = 0; i < 20; i++) step(1, i == 0, lb);
    chk("s5_wv_count", cnt_wv, 6);
    chk("s5_le_count", cnt_le, 4);
    chk("s5_fd_count", cnt_fd, 1);

    // Second frame_start lands in the DONE cycle and is dropped.
    step(1, 1, lb);
    chk("s6_done_drop", lb, 0);
    step(1, 1, lb);
    chk("s6_accept", lb, 1);
    chk("s6_busy", busy, 1);
    chk("s6_sync", sync_err, 0);
    clear_counts();
    for (int i = 0; i < 19; i++) step(1, 0, lb);
    chk("s6_fd_count", cnt_fd, 1);
    chk("s6_wv_count", cnt_wv, 6);

    // Random traffic with occasional frame starts, checked against the model.
    for (int i = 0; i < 2000; i++) begin
      fs = ($urandom_range(0, 99) < 4);
      step($urandom_range(0, 99) < 75, fs, lb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_scheduler.md
# line_buffer_scheduler

Sequences the pixel stream into the cascade of line buffers that feeds the pupil-detection window kernels. It tracks the row and column of every accepted pixel and drives the `clock_enable` of all line buffers in the cascade. It also flags when the KERNEL×KERNEL window formed by the line-buffer taps holds a complete neighbourhood, and frames the image with line-end and frame-done pulses. It sits between the camera/pixel source and the line-buffer chain plus window kernels.

## Interface

- `IMG_WIDTH`, default 317: pixels per line. Equals the line-buffer depth.
- `IMG_HEIGHT`, default 240: lines per frame.
- `KERNEL`, default 3: window size. Must be ≥ 2 and ≤ both image dimensions.
- `COL_W`, default 9: column counter width. Requires `2**COL_W >= IMG_WIDTH`.
- `ROW_W`, default 8: row counter width. Requires `2**ROW_W >= IMG_HEIGHT`.

Ports (name, direction, width, meaning):

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pixel_valid` in 1: a pixel is present on the source bus this cycle.
- `frame_start` in 1: marks the first pixel of a frame. Only meaningful while `pixel_valid` = 1.
- `lb_enable` out 1: combinational. Wire to `clock_enable` of every line buffer and window register.
- `window_valid` out 1: registered. The window taps hold a full neighbourhood centred on the pixel at (`row_count`−(KERNEL−1)/2, `col_count`−(KERNEL−1)/2).
- `col_count` out COL_W: registered column of the most recently accepted pixel.
- `row_count` out ROW_W: registered row of the most recently accepted pixel.
- `line_end` out 1: registered. One-cycle pulse after the last pixel of each line is accepted.
- `frame_done` out 1: registered. One-cycle pulse after the last pixel of the frame is accepted.
- `busy` out 1: registered. High while in FILL or ACTIVE.
- `sync_err` out 1: registered. One-cycle pulse when a frame restarts mid-frame.

## Operation

- **Accept rule.** A pixel is accepted when `lb_enable` = 1.
  - `lb_enable` = `pixel_valid` & ((state == IDLE & `frame_start`) | state ∈ {FILL, ACTIVE}).
- **States.** IDLE, FILL, ACTIVE, DONE.
  - IDLE: waits for an accepted pixel with `frame_start`. `pixel_valid` without `frame_start` is ignored, so no shift occurs. On accept, the pixel is placed at (0,0) and the state goes to FILL.
  - FILL: rows 0..KERNEL−2. On accept of the last column of row KERNEL−2, go to ACTIVE.
  - ACTIVE: rows KERNEL−1..IMG_HEIGHT−1. On accept of (IMG_HEIGHT−1, IMG_WIDTH−1), go to DONE.
  - DONE: lasts exactly one cycle, then IDLE. `lb_enable` = 0 in DONE, so a pixel offered in DONE is dropped even if it carries `frame_start`.
- **Position counters.** Internal next-position counters (nx, ny):
  - Clear to (0,0) at frame start.
  - nx increments on accept and wraps from IMG_WIDTH−1 to 0.
  - ny increments on that wrap.
  - No saturation is needed, because the frame end forces IDLE.
- **Registered outputs on an accepted pixel at (r,c):**
  - `col_count` ← c and `row_count` ← r.
  - `window_valid` ← (r ≥ KERNEL−1) & (c ≥ KERNEL−1).
  - `line_end` ← (c == IMG_WIDTH−1).
  - `frame_done` ← (r == IMG_HEIGHT−1 & c == IMG_WIDTH−1).
- **No accept.** `window_valid`, `line_end` and `frame_done` ← 0. `col_count` and `row_count` hold.
- **Frame start in FILL or ACTIVE.** If `frame_start` = 1 with `pixel_valid` = 1 in FILL or ACTIVE:
  - `sync_err` ← 1.
  - The pixel is accepted as (0,0).
  - The state goes to FILL and `window_valid` ← 0.
  - Stale line-buffer contents are not cleared. The fill rows mask them.
- **Frame start on the last pixel.** `frame_start` coincident with the last pixel of a frame counts as a restart: `sync_err` = 1, `frame_done` = 0, state goes to FILL.
- **Reset.** `reset_n` low at any time, including mid-frame, forces IDLE immediately. It does not wait for a clock edge.

## Timing

- **Reset values.** `window_valid`, `line_end`, `frame_done`, `busy` and `sync_err` = 0. `col_count` and `row_count` = 0. State = IDLE.
- **`lb_enable` during reset.** `lb_enable` = 0 while `reset_n` is low.
- **Latency.**
  - `lb_enable` has zero latency relative to `pixel_valid`.
  - All status outputs are valid in the cycle after the accepting edge. This aligns them with the line-buffer outputs updated on that same edge.
- **Throughput.** One pixel per clock. Arbitrary gaps in `pixel_valid` are allowed; counters and state hold during gaps.
- **`busy`.**
  - Rises the cycle after the frame-start accept.
  - Falls in the DONE cycle, i.e. the same cycle `frame_done` = 1.
- **Back-to-back frames.** The earliest next-frame accept is the cycle after DONE, which gives a one-cycle inter-frame gap.

## Test plan

All scenarios use IMG_WIDTH=5, IMG_HEIGHT=4, KERNEL=3.

1. Reset, then 20 continuous pixels with `frame_start` on the first.
   - `lb_enable` high for 20 cycles.
   - `window_valid` pulses exactly 6 times, at positions (2,2),(2,3),(2,4),(3,2),(3,3),(3,4).
   - `line_end` pulses 4 times; `frame_done` pulses once, with `row_count`=3, `col_count`=4.
   - `busy` is high from the cycle after the first accept until the cycle `frame_done` = 1, where it drops to 0.
2. Same frame with `pixel_valid` toggling 1/0 → identical output sequence on accepted cycles; outputs hold or clear as specified during gaps.
3. 3 pixels without `frame_start` in IDLE → `lb_enable`=0, no counter change; the next `frame_start` pixel is accepted at (0,0).
4. `frame_start` at accept index 12 mid-frame → `sync_err` one-cycle pulse, `row_count`=0, `col_count`=0, state FILL. No `window_valid` until 12 further accepts.
5. `reset_n` low at accept index 15 → all outputs 0 with no clock edge needed; the following `frame_start` frame behaves exactly as scenario 1.
6. Two frames back-to-back, the second `frame_start` in the DONE cycle → that pixel is dropped; the second `frame_start` is accepted one cycle later and runs normally.
